// File: rtl/lstm_seq_ctrl_if.sv
// Handshake and sequencing bundle between the LSTM sequence controller and
// the input memory / shift register / lstm core it drives.
interface lstm_seq_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_start;
    logic             i_wupd;
    logic [WIDTH-1:0] o_addr;
    logic             o_shift_en;
    logic             o_lstm_en;
    logic             o_h_valid;
    logic [WIDTH-1:0] o_step;
    logic             o_sel;
    logic             o_wupd_ack;
    logic             o_busy;
    logic             o_done;

    modport master (
        input  i_start, i_wupd,
        output o_addr, o_shift_en, o_lstm_en, o_h_valid, o_step,
               o_sel, o_wupd_ack, o_busy, o_done
    );

    modport slave (
        output i_start, i_wupd,
        input  o_addr, o_shift_en, o_lstm_en, o_h_valid, o_step,
               o_sel, o_wupd_ack, o_busy, o_done
    );
endinterface

// File: rtl/lstm_seq_ctrl.sv
// Sequencing controller for the single-layer LSTM forward datapath: fills the
// input window, runs the timestep loop and owns the weight-source select.
module lstm_seq_ctrl #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned NUM            = 35,
    parameter int unsigned NUM_ITERATIONS = 8,
    parameter int unsigned LSTM_LAT       = 4
) (
    input  logic               clk,
    input  logic               rst,
    lstm_seq_ctrl_if.master    bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FILL    = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_ADVANCE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [WIDTH-1:0] FILL_LAST = WIDTH'(NUM - 2);
    localparam logic [WIDTH-1:0] COMP_LAST = WIDTH'(LSTM_LAT - 1);
    localparam logic [WIDTH-1:0] STEP_LAST = WIDTH'(NUM_ITERATIONS - 1);

    logic [2:0]       state, state_nxt;
    logic [WIDTH-1:0] cnt,   cnt_nxt;
    logic [WIDTH-1:0] addr,  addr_nxt;
    logic [WIDTH-1:0] step,  step_nxt;
    logic             sel,   sel_nxt;
    logic             pend,  pend_nxt;
    logic             ack,   ack_nxt;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            addr  <= '0;
            step  <= '0;
            sel   <= 1'b0;
            pend  <= 1'b0;
            ack   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            addr  <= addr_nxt;
            step  <= step_nxt;
            sel   <= sel_nxt;
            pend  <= pend_nxt;
            ack   <= ack_nxt;
        end
    end

    // Next-state, counters and weight-update handshake
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = addr;
        step_nxt  = step;
        sel_nxt   = sel;
        ack_nxt   = 1'b0;
        pend_nxt  = pend | bus.i_wupd;

        case (state)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_nxt = S_FILL;
                    cnt_nxt   = '0;
                    addr_nxt  = '0;
                    step_nxt  = '0;
                end
            end
            S_FILL: begin
                if (cnt == FILL_LAST) begin
                    state_nxt = S_COMPUTE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt  = cnt + WIDTH'(1);
                    addr_nxt = addr + WIDTH'(1);
                end
            end
            S_COMPUTE: begin
                if (cnt == COMP_LAST) begin
                    cnt_nxt = '0;
                    if (step == STEP_LAST) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ADVANCE;
                        addr_nxt  = addr + WIDTH'(1);
                    end
                end else begin
                    cnt_nxt = cnt + WIDTH'(1);
                end
            end
            S_ADVANCE: begin
                state_nxt = S_COMPUTE;
                cnt_nxt   = '0;
                step_nxt  = step + WIDTH'(1);
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Weight switch lands on the first idle cycle so o_sel is stable while busy
        if (state_nxt == S_IDLE && pend_nxt) begin
            sel_nxt  = 1'b1;
            ack_nxt  = 1'b1;
            pend_nxt = 1'b0;
        end
    end

    assign bus.o_addr     = addr;
    assign bus.o_step     = step;
    assign bus.o_sel      = sel;
    assign bus.o_wupd_ack = ack;
    assign bus.o_shift_en = (state == S_FILL) || (state == S_ADVANCE);
    assign bus.o_lstm_en  = (state == S_COMPUTE);
    assign bus.o_h_valid  = (state == S_COMPUTE) && (cnt == COMP_LAST);
    assign bus.o_busy     = (state != S_IDLE);
    assign bus.o_done     = (state == S_DONE);

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Self-checking bench for lstm_seq_ctrl: scenario tasks plus a scoreboard of
// expected o_h_valid / o_done events keyed by absolute cycle.
module tb_lstm_seq_ctrl;

    localparam int WIDTH    = 32;
    localparam int NUM      = 35;
    localparam int NI       = 8;
    localparam int LAT      = 4;
    localparam int SEQ_DONE = NUM - 1 + NI * (LAT + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lstm_seq_ctrl_if #(.WIDTH(WIDTH)) bus();

    lstm_seq_ctrl #(
        .WIDTH(WIDTH), .NUM(NUM), .NUM_ITERATIONS(NI), .LSTM_LAT(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int cyc;
        int step;
        int addr;
    } hv_t;

    hv_t hq[$];
    int  dq[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every strobe must match the next expected event
    always @(negedge clk) begin
        hv_t e;
        int  d;
        if (!rst) begin
            if (bus.o_h_valid === 1'b1) begin
                checks++;
                if (hq.size() == 0) begin
                    failures++;
                    $display("FAIL h_valid_unexpected cyc=%0d step=%0d", cyc, bus.o_step);
                end else begin
                    e = hq.pop_front();
                    if (cyc !== e.cyc || int'(bus.o_step) !== e.step || int'(bus.o_addr) !== e.addr) begin
                        failures++;
                        $display("FAIL h_valid_event got cyc=%0d step=%0d addr=%0d exp cyc=%0d step=%0d addr=%0d",
                                 cyc, bus.o_step, bus.o_addr, e.cyc, e.step, e.addr);
                    end
                end
            end
            if (bus.o_done === 1'b1) begin
                checks++;
                if (dq.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected cyc=%0d", cyc);
                end else begin
                    d = dq.pop_front();
                    if (cyc !== d) begin
                        failures++;
                        $display("FAIL done_cycle got=%0d exp=%0d", cyc, d);
                    end
                end
            end
        end
    end

    // Pulse i_start (with optional i_wupd) from a negedge; returns at cycle 1
    task automatic do_start(input logic w, output int base);
        bus.i_start = 1'b1;
        bus.i_wupd  = w;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_wupd  = 1'b0;
        base = cyc - 1;
        for (int i = 0; i < NI; i++) begin
            hv_t e;
            e.cyc  = base + NUM - 1 + LAT + i * (LAT + 1);
            e.step = i;
            e.addr = NUM - 2 + i;
            hq.push_back(e);
        end
        dq.push_back(base + SEQ_DONE);
    endtask

    task automatic test_reset();
        logic [2*WIDTH+6:0] v;
        v = {bus.o_addr, bus.o_step, bus.o_shift_en, bus.o_lstm_en, bus.o_h_valid,
             bus.o_sel, bus.o_wupd_ack, bus.o_busy, bus.o_done};
        checks++;
        if (v !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", v);
        end
        rst = 1'b0;
        @(negedge clk);
        v = {bus.o_addr, bus.o_step, bus.o_shift_en, bus.o_lstm_en, bus.o_h_valid,
             bus.o_sel, bus.o_wupd_ack, bus.o_busy, bus.o_done};
        checks++;
        if (v !== '0) begin
            failures++;
            $display("FAIL idle_after_reset got=%h exp=0", v);
        end
    endtask

    task automatic test_first_window();
        int  base;
        int  n;
        logic exp_shift, exp_lstm;
        int  exp_addr;
        do_start(1'b0, base);
        for (int r = 1; r <= NUM + LAT; r++) begin
            exp_shift = (r <= NUM - 1) || (r == NUM + LAT);
            exp_lstm  = (r >= NUM) && (r <= NUM + LAT - 1);
            exp_addr  = (r <= NUM - 1) ? r - 1 : ((r <= NUM - 1 + LAT) ? NUM - 2 : NUM - 1);
            checks++;
            if (bus.o_shift_en !== exp_shift || bus.o_lstm_en !== exp_lstm || int'(bus.o_addr) !== exp_addr) begin
                failures++;
                $display("FAIL window_r%0d got shift=%b lstm=%b addr=%0d exp shift=%b lstm=%b addr=%0d",
                         r, bus.o_shift_en, bus.o_lstm_en, bus.o_addr, exp_shift, exp_lstm, exp_addr);
            end
            @(negedge clk);
        end
        n = 0;
        while (bus.o_busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL window_drain_timeout busy=%b exp=0", bus.o_busy);
        end
    endtask

    task automatic test_full_sequence();
        int base;
        do_start(1'b0, base);
        for (int r = 1; r <= SEQ_DONE + 2; r++) begin
            checks++;
            if (bus.o_busy !== (r <= SEQ_DONE)) begin
                failures++;
                $display("FAIL busy_r%0d got=%b exp=%b", r, bus.o_busy, (r <= SEQ_DONE));
            end
            if (r == SEQ_DONE + 1) begin
                checks++;
                if (int'(bus.o_addr) !== NUM - 2 + NI - 1) begin
                    failures++;
                    $display("FAIL final_addr got=%0d exp=%0d", bus.o_addr, NUM - 2 + NI - 1);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wupd_mid();
        int base;
        do_start(1'b0, base);
        for (int r = 1; r <= 80; r++) begin
            bus.i_wupd = (r == 50);
            checks++;
            if (bus.o_sel !== (r >= SEQ_DONE + 1) || bus.o_wupd_ack !== (r == SEQ_DONE + 1)) begin
                failures++;
                $display("FAIL wupd_mid_r%0d got sel=%b ack=%b exp sel=%b ack=%b",
                         r, bus.o_sel, bus.o_wupd_ack, (r >= SEQ_DONE + 1), (r == SEQ_DONE + 1));
            end
            @(negedge clk);
        end
        bus.i_wupd = 1'b0;
        do_start(1'b0, base);
        for (int r = 1; r <= SEQ_DONE + 2; r++) begin
            checks++;
            if (bus.o_sel !== 1'b1 || bus.o_wupd_ack !== 1'b0) begin
                failures++;
                $display("FAIL wupd_next_seq_r%0d got sel=%b ack=%b exp sel=1 ack=0", r, bus.o_sel, bus.o_wupd_ack);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_wupd_together();
        int base;
        int acks;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start(1'b1, base);
        acks = 0;
        for (int r = 1; r <= 80; r++) begin
            bus.i_wupd = (r == 20) || (r == 60);
            if (bus.o_wupd_ack === 1'b1) acks++;
            checks++;
            if (bus.o_sel !== (r > SEQ_DONE) || bus.o_wupd_ack !== (r == SEQ_DONE + 1)) begin
                failures++;
                $display("FAIL together_r%0d got sel=%b ack=%b exp sel=%b ack=%b",
                         r, bus.o_sel, bus.o_wupd_ack, (r > SEQ_DONE), (r == SEQ_DONE + 1));
            end
            @(negedge clk);
        end
        bus.i_wupd = 1'b0;
        checks++;
        if (acks !== 1) begin
            failures++;
            $display("FAIL single_ack got=%0d exp=1", acks);
        end
    endtask

    task automatic test_ignored_start();
        int base;
        int dn;
        do_start(1'b0, base);
        dn = 0;
        for (int r = 1; r <= 90; r++) begin
            bus.i_start = (r == 10) || (r == 40);
            if (bus.o_done === 1'b1) dn++;
            @(negedge clk);
        end
        bus.i_start = 1'b0;
        checks++;
        if (dn !== 1) begin
            failures++;
            $display("FAIL done_count got=%0d exp=1", dn);
        end
    endtask

    task automatic test_mid_reset();
        int base;
        checks++;
        if (bus.o_sel !== 1'b1) begin
            failures++;
            $display("FAIL sel_before_reset got=%b exp=1", bus.o_sel);
        end
        do_start(1'b0, base);
        for (int r = 1; r <= 45; r++) begin
            bus.i_wupd = (r == 20);
            if (r == 45) begin
                rst = 1'b1;
                hq.delete();
                dq.delete();
            end
            @(negedge clk);
        end
        bus.i_wupd = 1'b0;
        rst = 1'b0;
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_sel !== 1'b0 || bus.o_addr !== '0 || bus.o_step !== '0 ||
            bus.o_done !== 1'b0 || bus.o_h_valid !== 1'b0 || bus.o_shift_en !== 1'b0 || bus.o_lstm_en !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_idle got busy=%b sel=%b addr=%0d step=%0d done=%b hv=%b exp all 0",
                     bus.o_busy, bus.o_sel, bus.o_addr, bus.o_step, bus.o_done, bus.o_h_valid);
        end
        for (int r = 47; r <= 90; r++) begin
            @(negedge clk);
            checks++;
            if (bus.o_busy !== 1'b0 || bus.o_sel !== 1'b0 || bus.o_wupd_ack !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_r%0d got busy=%b sel=%b ack=%b exp 0 0 0",
                         r, bus.o_busy, bus.o_sel, bus.o_wupd_ack);
            end
        end
        test_first_window();
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_wupd  = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_first_window();
        test_full_sequence();
        test_wupd_mid();
        test_start_wupd_together();
        test_ignored_start();
        test_mid_reset();
        repeat (5) @(negedge clk);
        checks++;
        if (hq.size() != 0 || dq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover h=%0d done=%0d exp 0 0", hq.size(), dq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
